// File: rtl/tetris_row_fetch.sv
// Per-scanline board row and piece-mask fetch; runs in hblank, commits both masks at end of line.
// Masks ready 4 cycles after fetch start; no backpressure, a late fetch shows up as a fetch_miss pulse.
module tetris_row_fetch #(
    parameter int BLOCK_PX   = 20,
    parameter int BOARD_ROWS = 20,
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int FETCH_X    = 640
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [15:0] piece_shape,
    input  logic [4:0]  piece_x,
    input  logic [5:0]  piece_y,
    output logic [4:0]  board_addr,
    input  logic [9:0]  board_data,
    output logic [9:0]  row,
    output logic [9:0]  piece_row,
    output logic        fetch_miss
);
    localparam int SUB_W     = (BLOCK_PX > 1) ? $clog2(BLOCK_PX) : 1;
    localparam int VIS_LINES = BOARD_ROWS * BLOCK_PX;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_BUILD} state_t;

    state_t           state_q, state_d;
    logic [4:0]       band_q, band_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             synced_q, synced_d;
    logic             pending_q, pending_d;
    logic             vis_q, vis_d;
    logic [15:0]      shape_q, shape_d;
    logic [4:0]       px_q, px_d;
    logic [5:0]       py_q, py_d;
    logic [4:0]       addr_q, addr_d;
    logic [9:0]       srow_q, srow_d;
    logic [9:0]       spiece_q, spiece_d;
    logic [9:0]       row_q, row_d;
    logic [9:0]       prow_q, prow_d;
    logic             miss_q, miss_d;

    logic [9:0]  ny;
    logic        commit;
    logic        row_ok;
    logic [6:0]  dy;
    logic [3:0]  nib;
    logic [4:0]  sh;
    logic [15:0] win;
    logic [9:0]  mask;

    assign ny     = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    assign commit = (DrawX == 10'(H_TOTAL - 1));
    assign row_ok = synced_q && (int'(band_q) < BOARD_ROWS) && vis_q;

    // Negative dy wraps to a large unsigned value, so one range test covers 0..3.
    // The nibble is placed in a window whose bit 15-(col+3) is board column col;
    // columns 0..9 then land on win[12:3] and anything outside is dropped.
    always_comb begin
        dy  = {2'b00, band_q} - {py_q[5], py_q};
        nib = 4'd0;
        if (dy[6:2] == 5'd0) begin
            case (dy[1:0])
                2'd0:    nib = shape_q[15:12];
                2'd1:    nib = shape_q[11:8];
                2'd2:    nib = shape_q[7:4];
                default: nib = shape_q[3:0];
            endcase
        end
        sh   = px_q + 5'd3;
        win  = {nib, 12'd0} >> sh;
        mask = win[12:3];
    end

    always_comb begin
        state_d   = state_q;
        band_d    = band_q;
        sub_d     = sub_q;
        synced_d  = synced_q;
        pending_d = pending_q;
        vis_d     = vis_q;
        shape_d   = shape_q;
        px_d      = px_q;
        py_d      = py_q;
        addr_d    = addr_q;
        srow_d    = srow_q;
        spiece_d  = spiece_q;
        row_d     = row_q;
        prow_d    = prow_q;
        miss_d    = 1'b0;

        // Commit first so a build landing on the same cycle still leaves pending set.
        if (commit) begin
            if (pending_q) begin
                row_d     = srow_q;
                prow_d    = spiece_q;
                pending_d = 1'b0;
            end else begin
                miss_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (DrawX == 10'(FETCH_X)) begin
                    shape_d = piece_shape;
                    px_d    = piece_x;
                    py_d    = piece_y;
                    vis_d   = int'(ny) < VIS_LINES;
                    if (ny == 10'd0) begin
                        band_d   = 5'd0;
                        sub_d    = '0;
                        synced_d = 1'b1;
                    end else if (sub_q == SUB_W'(BLOCK_PX - 1)) begin
                        sub_d = '0;
                        if (band_q != 5'd31) begin
                            band_d = band_q + 5'd1;
                        end
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                    state_d = S_READ;
                end
            end
            S_READ: begin
                addr_d  = band_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_BUILD;
            end
            S_BUILD: begin
                srow_d    = row_ok ? board_data : 10'd0;
                spiece_d  = row_ok ? mask : 10'd0;
                pending_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            band_q    <= 5'd0;
            sub_q     <= '0;
            synced_q  <= 1'b0;
            pending_q <= 1'b0;
            vis_q     <= 1'b0;
            shape_q   <= 16'd0;
            px_q      <= 5'd0;
            py_q      <= 6'd0;
            addr_q    <= 5'd0;
            srow_q    <= 10'd0;
            spiece_q  <= 10'd0;
            row_q     <= 10'd0;
            prow_q    <= 10'd0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            band_q    <= band_d;
            sub_q     <= sub_d;
            synced_q  <= synced_d;
            pending_q <= pending_d;
            vis_q     <= vis_d;
            shape_q   <= shape_d;
            px_q      <= px_d;
            py_q      <= py_d;
            addr_q    <= addr_d;
            srow_q    <= srow_d;
            spiece_q  <= spiece_d;
            row_q     <= row_d;
            prow_q    <= prow_d;
            miss_q    <= miss_d;
        end
    end

    assign board_addr = addr_q;
    assign row        = row_q;
    assign piece_row  = prow_q;
    assign fetch_miss = miss_q;

endmodule

// File: tb/tb_tetris_row_fetch.sv
// Bench for tetris_row_fetch on a shrunken raster (4-px rows, 64x140 lines) so several frames fit.
// A line-level reference model predicts row/piece_row/fetch_miss/board_addr from the raster rules.
module tb_tetris_row_fetch;
    localparam int BPX   = 4;
    localparam int BROWS = 20;
    localparam int HT    = 64;
    localparam int VT    = 140;
    localparam int FX    = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  dx, dy;
    logic [15:0] shape;
    logic [4:0]  px;
    logic [5:0]  py;
    logic [4:0]  addr;
    logic [9:0]  bdata;
    logic [9:0]  row, prow;
    logic        miss;
    logic [9:0]  ram [32];

    always #5 clk = ~clk;

    always @(posedge clk) bdata <= ram[addr];

    tetris_row_fetch #(
        .BLOCK_PX(BPX), .BOARD_ROWS(BROWS), .H_TOTAL(HT), .V_TOTAL(VT), .FETCH_X(FX)
    ) dut (
        .Clk(clk), .Reset(rst), .DrawX(dx), .DrawY(dy),
        .piece_shape(shape), .piece_x(px), .piece_y(py),
        .board_addr(addr), .board_data(bdata),
        .row(row), .piece_row(prow), .fetch_miss(miss)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (line %0d x %0d)", tag, got, exp, dy, dx);
        end
    endtask

    // Reference state: what the outputs should be after the coming clock edge.
    logic [9:0] m_row, m_prow, m_srow, m_sprow;
    logic       m_pend, m_synced, m_miss, m_addr_chk;
    int         m_addr;

    function automatic logic [9:0] ref_piece(input logic [15:0] s, input int x, input int y, input int band);
        logic [9:0] m = 10'd0;
        int d = band - y;
        if (d < 0 || d > 3) return 10'd0;
        for (int k = 0; k < 4; k++) begin
            int c = x + k;
            if (((32'(s) >> (15 - 4 * d - k)) & 32'd1) != 0 && c >= 0 && c <= 9)
                m = m | (10'd1 << (9 - c));
        end
        return m;
    endfunction

    task automatic model_edge();
        int  ny;
        int  band;
        logic valid;
        m_miss = 1'b0;
        if (rst) begin
            m_row = 0; m_prow = 0; m_pend = 0; m_synced = 0; m_addr_chk = 0;
            return;
        end
        ny = (int'(dy) == VT - 1) ? 0 : int'(dy) + 1;
        if (int'(dx) == HT - 1) begin
            if (m_pend) begin
                m_row = m_srow; m_prow = m_sprow; m_pend = 0;
            end else begin
                m_miss = 1'b1;
            end
        end
        if (int'(dx) == FX) begin
            if (ny == 0) m_synced = 1;
            band  = ny / BPX;
            valid = m_synced && band < BROWS && ny < BROWS * BPX;
            m_srow = 10'd0;
            m_sprow = 10'd0;
            if (valid) begin
                m_srow  = ram[band];
                m_sprow = ref_piece(shape, int'($signed(px)), int'($signed(py)), band);
            end
            m_pend     = 1;
            m_addr_chk = m_synced;
            m_addr     = (band > 31) ? 31 : band;
        end
    endtask

    task automatic run_cycle();
        model_edge();
        @(posedge clk);
        #1;
        if (int'(dx) == 5) begin
            chk("row", row, m_row);
            chk("piece_row", prow, m_prow);
        end
        if (int'(dx) == HT - 1 || dx == 10'd0) chk("fetch_miss", miss, m_miss);
        if (int'(dx) == FX + 1 && m_addr_chk) chk("board_addr", addr, m_addr);
    endtask

    task automatic rand_piece();
        shape = 16'($urandom);
        px    = 5'(int'($urandom_range(12)) - 3);
        py    = 6'(int'($urandom_range(22)) - 3);
    endtask

    task automatic directed(input int f, input int ln, input int x);
        if (f == 1 && x == 5) begin
            if (ln == 2)  chk("f1_row0", row, 10'h3FF);
            if (ln == 21) chk("f1_row5", row, 10'h201);
            if (ln == 85) chk("f1_below", row, 10'h000);
            if (ln == 5)  chk("f1_ipiece", prow, 10'h078);
            if (ln == 9)  chk("f1_ipiece_off", prow, 10'h000);
        end
        if (f == 2) begin
            if (ln == 1 && x == 5)       chk("f2_clip_left", prow, 10'h200);
            if (ln == 3 && x == 5)       chk("f2_latched", prow, 10'h200);
            if (ln == 3 && x == FX + 20) chk("f2_no_tear", prow, 10'h200);
            if (ln == 5 && x == 5)       chk("f2_clip_right", prow, 10'h001);
        end
        if (f == 3) begin
            if (ln == 60 && x == 5) begin
                chk("f3_rst_row", row, 10'h000);
                chk("f3_rst_piece", prow, 10'h000);
            end
            if (ln == 70 && x == HT - 1) chk("f3_abort_miss", miss, 1'b1);
            if (ln == 90 && x == HT - 1) chk("f3_late_rst_miss", miss, 1'b1);
        end
    endtask

    initial begin
        int chg_x;
        for (int i = 0; i < 32; i++) ram[i] = 10'd0;
        ram[0] = 10'h3FF;
        ram[5] = 10'h201;
        m_row = 0; m_prow = 0; m_srow = 0; m_sprow = 0;
        m_pend = 0; m_synced = 0; m_miss = 0; m_addr_chk = 0; m_addr = 0;
        shape = 16'h0F00; px = 5'd3; py = 6'd0;
        dy = 10'(VT - 1);
        chg_x = 0;

        // Lead-in: last line of a frame, reset for the first few pixels.
        for (int x = 0; x < HT; x++) begin
            dx  = 10'(x);
            rst = (x < 3);
            run_cycle();
            if (x == 0) begin
                chk("reset_row", row, 10'h000);
                chk("reset_piece", prow, 10'h000);
                chk("reset_addr", addr, 5'h00);
                chk("reset_miss", miss, 1'b0);
            end
        end

        for (int f = 1; f <= 4; f++) begin
            for (int ln = 0; ln < VT; ln++) begin
                for (int x = 0; x < HT; x++) begin
                    dx  = 10'(x);
                    dy  = 10'(ln);
                    rst = 1'b0;
                    if (f >= 2 && ln == 0 && x == 0)
                        for (int i = 0; i < 32; i++) ram[i] = 10'($urandom);
                    if (f == 2) begin
                        if (ln == 0 && x == 0) begin
                            shape = 16'hCC00; px = 5'h1F; py = 6'd0;
                        end
                        if (ln == 2 && x == FX + 10) px = 5'd9;
                    end
                    if (f >= 3) begin
                        if (x == 0) chg_x = int'($urandom_range(HT - 1));
                        if (x == chg_x) rand_piece();
                    end
                    if (f == 3)
                        rst = (ln == 50 && x >= 20 && x < 23) ||
                              (ln == 70 && x == FX + 1) ||
                              (ln == 90 && x == FX + 6);
                    run_cycle();
                    directed(f, ln, x);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
